// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_pkg
// Description : Shared types and encodings for the multicycle MIPS control
//               unit: FSM state enum, opcode/funct values, ALU function codes
//               and datapath mux select enums.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_pkg;

  // Controller states, 4-bit encoding
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_MEM   = 4'd7,
    S_WB_ALU   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_HALT     = 4'd11
  } state_e;

  // Primary opcodes, IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes, IR[5:0]
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  // ALU function codes {sub,bool1,bool0,shft,math}
  localparam logic [4:0] ALUFN_ADD  = 5'b00001;
  localparam logic [4:0] ALUFN_SUB  = 5'b10001;
  localparam logic [4:0] ALUFN_AND  = 5'b00000;
  localparam logic [4:0] ALUFN_OR   = 5'b00100;
  localparam logic [4:0] ALUFN_XOR  = 5'b01000;
  localparam logic [4:0] ALUFN_NOR  = 5'b01100;
  localparam logic [4:0] ALUFN_SLT  = 5'b10011;
  localparam logic [4:0] ALUFN_SLTU = 5'b10111;
  localparam logic [4:0] ALUFN_SLL  = 5'b00010;
  localparam logic [4:0] ALUFN_SRL  = 5'b01010;
  localparam logic [4:0] ALUFN_SRA  = 5'b01110;

  // ALU operand B select
  typedef enum logic [1:0] {
    SRCB_B    = 2'd0,
    SRCB_FOUR = 2'd1,
    SRCB_SEXT = 2'd2,
    SRCB_ZEXT = 2'd3
  } srcb_e;

  // PC next-value select
  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'd0,
    PCSRC_ALUOUT = 2'd1,
    PCSRC_JUMP   = 2'd2,
    PCSRC_REGA   = 2'd3
  } pc_src_e;

  // Register file write-data select
  typedef enum logic [1:0] {
    WD_ALUOUT = 2'd0,
    WD_MDR    = 2'd1,
    WD_PC     = 2'd2,
    WD_LUI    = 2'd3
  } wd_src_e;

  // Register file destination select
  typedef enum logic [1:0] {
    DST_RT = 2'd0,
    DST_RD = 2'd1,
    DST_RA = 2'd2
  } reg_dst_e;

  // Logical immediates take a zero-extended operand; all others sign-extend
  function automatic logic uses_zext_imm(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

  // States in which the controller waits on the memory handshake
  function automatic logic is_wait_state(input state_e st);
    return (st == S_FETCH) || (st == S_MEM_RD) || (st == S_MEM_WR);
  endfunction

endpackage : mc_pkg
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_decoder
// Description : Combinational decode of {op,funct} into the ALU function
//               code. valid flags every instruction the controller supports,
//               including those that do not use the ALU result.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [4:0] alufn,
  output logic       valid
);

  // Map opcode / function field to ALU operation and legality
  always_comb begin
    alufn = ALUFN_ADD;
    valid = 1'b1;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_ADDU: alufn = ALUFN_ADD;
          F_SUB, F_SUBU: alufn = ALUFN_SUB;
          F_AND:         alufn = ALUFN_AND;
          F_OR:          alufn = ALUFN_OR;
          F_XOR:         alufn = ALUFN_XOR;
          F_NOR:         alufn = ALUFN_NOR;
          F_SLT:         alufn = ALUFN_SLT;
          F_SLTU:        alufn = ALUFN_SLTU;
          F_SLL:         alufn = ALUFN_SLL;
          F_SRL:         alufn = ALUFN_SRL;
          F_SRA:         alufn = ALUFN_SRA;
          F_JR:          alufn = ALUFN_ADD;
          default:       valid = 1'b0;
        endcase
      end
      OP_ADDI:         alufn = ALUFN_ADD;
      OP_SLTI:         alufn = ALUFN_SLT;
      OP_SLTIU:        alufn = ALUFN_SLTU;
      OP_ANDI:         alufn = ALUFN_AND;
      OP_ORI:          alufn = ALUFN_OR;
      OP_XORI:         alufn = ALUFN_XOR;
      OP_LUI:          alufn = ALUFN_ADD;
      OP_LW, OP_SW:    alufn = ALUFN_ADD;
      OP_BEQ, OP_BNE:  alufn = ALUFN_SUB;
      OP_J, OP_JAL:    alufn = ALUFN_ADD;
      default:         valid = 1'b0;
    endcase
  end

endmodule : alu_decoder
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mc_control_fsm
// Description : Multicycle MIPS control unit. Sequences FETCH / DECODE /
//               EXEC / MEM / WB for each instruction, drives ALU function and
//               datapath enables, stalls on mem_ready and raises a sticky
//               bus_err if memory fails to answer within WAIT_LIMIT cycles.
//               Build option MC_ILLEGAL_TRAP_EN: unknown instructions halt the
//               controller and set the sticky illegal_op output; otherwise
//               they execute as a NOP and illegal_op does not exist.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int WAIT_LIMIT = 15
)(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       FlagZ,
  input  logic       mem_ready,
  output logic [4:0] ALUfn,
  output logic       alu_srca,
  output logic [1:0] alu_srcb,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       ir_en,
  output logic       iord,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       reg_wr,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_src,
  output logic       bus_err
`ifdef MC_ILLEGAL_TRAP_EN
  ,
  output logic       illegal_op
`endif
);

  localparam int                 c_cnt_w      = $clog2(WAIT_LIMIT + 1);
  localparam logic [c_cnt_w-1:0] c_wait_limit = c_cnt_w'(WAIT_LIMIT);

  state_e             r_state;
  state_e             w_state_next;
  logic [c_cnt_w-1:0] r_wait_cnt;
  logic               r_bus_err;
  logic               w_set_bus_err;
  logic               w_wait_expired;

  // Ungated strobes; reset low masks them at the outputs
  logic               w_pc_en;
  logic               w_ir_en;
  logic               w_mem_wr;
  logic               w_reg_wr;

  logic [4:0]         w_dec_alufn;
  logic               w_dec_valid;

  logic               w_is_rtype;
  logic               w_is_jr;
  logic               w_is_jal;
  logic               w_is_lui;
  logic               w_is_beq;
  logic               w_is_sw;

`ifdef MC_ILLEGAL_TRAP_EN
  logic               r_illegal_op;
  logic               w_set_illegal;
`endif

  alu_decoder u_alu_decoder (
    .op    (op),
    .funct (funct),
    .alufn (w_dec_alufn),
    .valid (w_dec_valid)
  );

  assign w_is_rtype = (op == OP_RTYPE);
  assign w_is_jr    = w_is_rtype && (funct == F_JR);
  assign w_is_jal   = (op == OP_JAL);
  assign w_is_lui   = (op == OP_LUI);
  assign w_is_beq   = (op == OP_BEQ);
  assign w_is_sw    = (op == OP_SW);

  // Waiting state has run out of patience; a ready on this cycle still wins
  assign w_wait_expired = !mem_ready && (r_wait_cnt == c_wait_limit);

  // Next-state and Moore output decode
  always_comb begin
    w_state_next  = r_state;
    w_set_bus_err = 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
    w_set_illegal = 1'b0;
`endif
    ALUfn    = ALUFN_ADD;
    alu_srca = 1'b0;
    alu_srcb = SRCB_B;
    w_pc_en  = 1'b0;
    pc_src   = PCSRC_ALU;
    w_ir_en  = 1'b0;
    iord     = 1'b0;
    mem_rd   = 1'b0;
    w_mem_wr = 1'b0;
    w_reg_wr = 1'b0;
    reg_dst  = DST_RT;
    wd_src   = WD_ALUOUT;

    case (r_state)
      S_FETCH: begin
        // PC+4 computed alongside the instruction read
        mem_rd   = 1'b1;
        alu_srcb = SRCB_FOUR;
        w_pc_en  = mem_ready;
        w_ir_en  = mem_ready;
        if (mem_ready) begin
          w_state_next = S_DECODE;
        end else if (w_wait_expired) begin
          w_set_bus_err = 1'b1;
          w_state_next  = S_HALT;
        end
      end

      S_DECODE: begin
        // Branch target precomputed into ALUOut while decoding
        alu_srcb = SRCB_SEXT;
        if (!w_dec_valid) begin
`ifdef MC_ILLEGAL_TRAP_EN
          w_set_illegal = 1'b1;
          w_state_next  = S_HALT;
`else
          w_state_next  = S_FETCH;
`endif
        end else begin
          case (op)
            OP_RTYPE:         w_state_next = w_is_jr ? S_JUMP : S_EXEC_R;
            OP_LW, OP_SW:     w_state_next = S_MEM_ADDR;
            OP_ADDI, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI:
                              w_state_next = S_EXEC_I;
            OP_LUI:           w_state_next = S_WB_ALU;
            OP_BEQ, OP_BNE:   w_state_next = S_BRANCH;
            OP_J, OP_JAL:     w_state_next = S_JUMP;
            default:          w_state_next = S_FETCH;
          endcase
        end
      end

      S_EXEC_R: begin
        alu_srca     = 1'b1;
        alu_srcb     = SRCB_B;
        ALUfn        = w_dec_alufn;
        w_state_next = S_WB_ALU;
      end

      S_EXEC_I: begin
        alu_srca     = 1'b1;
        alu_srcb     = uses_zext_imm(op) ? SRCB_ZEXT : SRCB_SEXT;
        ALUfn        = w_dec_alufn;
        w_state_next = S_WB_ALU;
      end

      S_WB_ALU: begin
        w_reg_wr     = 1'b1;
        reg_dst      = w_is_rtype ? DST_RD : DST_RT;
        wd_src       = w_is_lui ? WD_LUI : WD_ALUOUT;
        w_state_next = S_FETCH;
      end

      S_MEM_ADDR: begin
        alu_srca     = 1'b1;
        alu_srcb     = SRCB_SEXT;
        w_state_next = w_is_sw ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        iord   = 1'b1;
        mem_rd = 1'b1;
        if (mem_ready) begin
          w_state_next = S_WB_MEM;
        end else if (w_wait_expired) begin
          w_set_bus_err = 1'b1;
          w_state_next  = S_HALT;
        end
      end

      S_MEM_WR: begin
        // Write request is a level held for the whole wait
        iord     = 1'b1;
        w_mem_wr = 1'b1;
        if (mem_ready) begin
          w_state_next = S_FETCH;
        end else if (w_wait_expired) begin
          w_set_bus_err = 1'b1;
          w_state_next  = S_HALT;
        end
      end

      S_WB_MEM: begin
        w_reg_wr     = 1'b1;
        wd_src       = WD_MDR;
        reg_dst      = DST_RT;
        w_state_next = S_FETCH;
      end

      S_BRANCH: begin
        ALUfn        = ALUFN_SUB;
        alu_srca     = 1'b1;
        alu_srcb     = SRCB_B;
        pc_src       = PCSRC_ALUOUT;
        w_pc_en      = w_is_beq ? FlagZ : !FlagZ;
        w_state_next = S_FETCH;
      end

      S_JUMP: begin
        w_pc_en = 1'b1;
        pc_src  = w_is_jr ? PCSRC_REGA : PCSRC_JUMP;
        if (w_is_jal) begin
          w_reg_wr = 1'b1;
          reg_dst  = DST_RA;
          wd_src   = WD_PC;
        end
        w_state_next = S_FETCH;
      end

      S_HALT: begin
        w_state_next = S_HALT;
      end

      default: begin
        w_state_next = S_FETCH;
      end
    endcase
  end

  // Strobes are forced low for as long as reset is asserted
  assign pc_en  = w_pc_en  & reset;
  assign ir_en  = w_ir_en  & reset;
  assign mem_wr = w_mem_wr & reset;
  assign reg_wr = w_reg_wr & reset;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Memory wait counter: clears on any state change, counts idle wait cycles
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wait_cnt <= '0;
    end else if (w_state_next != r_state) begin
      r_wait_cnt <= '0;
    end else if (is_wait_state(r_state) && !mem_ready) begin
      r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
    end
  end

  // Sticky bus error flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bus_err <= 1'b0;
    end else if (w_set_bus_err) begin
      r_bus_err <= 1'b1;
    end
  end

  assign bus_err = r_bus_err;

`ifdef MC_ILLEGAL_TRAP_EN
  // Sticky illegal-instruction flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_illegal_op <= 1'b0;
    end else if (w_set_illegal) begin
      r_illegal_op <= 1'b1;
    end
  end

  assign illegal_op = r_illegal_op;
`endif

endmodule : mc_control_fsm
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_control_fsm
// Description : Self-checking bench for mc_control_fsm. Per-cycle expected
//               outputs (with a care mask) are queued by the driver and
//               compared against the DUT on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       FlagZ;
  logic       mem_ready;
  logic [4:0] ALUfn;
  logic       alu_srca;
  logic [1:0] alu_srcb;
  logic       pc_en;
  logic [1:0] pc_src;
  logic       ir_en;
  logic       iord;
  logic       mem_rd;
  logic       mem_wr;
  logic       reg_wr;
  logic [1:0] reg_dst;
  logic [1:0] wd_src;
  logic       bus_err;
`ifdef MC_ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  always #5 clk = ~clk;

  mc_control_fsm #(.WAIT_LIMIT(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .funct     (funct),
    .FlagZ     (FlagZ),
    .mem_ready (mem_ready),
    .ALUfn     (ALUfn),
    .alu_srca  (alu_srca),
    .alu_srcb  (alu_srcb),
    .pc_en     (pc_en),
    .pc_src    (pc_src),
    .ir_en     (ir_en),
    .iord      (iord),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .reg_wr    (reg_wr),
    .reg_dst   (reg_dst),
    .wd_src    (wd_src),
    .bus_err   (bus_err)
`ifdef MC_ILLEGAL_TRAP_EN
    ,
    .illegal_op(illegal_op)
`endif
  );

  typedef enum logic [3:0] {
    P_RESET, P_FETCH, P_DECODE, P_EXEC_R, P_EXEC_I, P_MEM_ADDR, P_MEM_RD,
    P_MEM_WR, P_WB_MEM, P_WB_ALU, P_BRANCH, P_JUMP, P_HALT, P_NONE
  } ph_e;

  typedef struct packed {
    logic [4:0] alufn;
    logic       alu_srca;
    logic [1:0] alu_srcb;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       ir_en;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
    logic [1:0] reg_dst;
    logic [1:0] wd_src;
    logic       bus_err;
  } outs_t;

  typedef struct {
    string tag;
    outs_t e;
    outs_t m;
    logic  ill;
    logic  ill_c;
  } sb_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] funct;
    logic       z;
    int         n;
    ph_e        seq [5];
  } vec_t;

  sb_t  sb_q [$];
  vec_t vt   [$];
  int   checks   = 0;
  int   failures = 0;

  // Reference ALU function codes
  function automatic logic [4:0] ref_alufn(input logic [5:0] o, input logic [5:0] f);
    logic [4:0] r;
    r = 5'b00001;
    if (o == 6'h00) begin
      case (f)
        6'h20, 6'h21: r = 5'b00001;
        6'h22, 6'h23: r = 5'b10001;
        6'h24:        r = 5'b00000;
        6'h25:        r = 5'b00100;
        6'h26:        r = 5'b01000;
        6'h27:        r = 5'b01100;
        6'h2A:        r = 5'b10011;
        6'h2B:        r = 5'b10111;
        6'h00:        r = 5'b00010;
        6'h02:        r = 5'b01010;
        6'h03:        r = 5'b01110;
        default:      r = 5'b00001;
      endcase
    end else begin
      case (o)
        6'h0A:   r = 5'b10011;
        6'h0B:   r = 5'b10111;
        6'h0C:   r = 5'b00000;
        6'h0D:   r = 5'b00100;
        6'h0E:   r = 5'b01000;
        default: r = 5'b00001;
      endcase
    end
    return r;
  endfunction

  // Expected outputs and care mask for one cycle in the given phase
  task automatic model(input ph_e ph, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic mr, input logic berr,
                       output outs_t e, output outs_t m);
    e = '0;
    m = '0;
    m.pc_en = 1'b1; m.ir_en = 1'b1; m.mem_rd = 1'b1; m.mem_wr = 1'b1;
    m.reg_wr = 1'b1; m.bus_err = 1'b1;
    e.bus_err = berr;
    case (ph)
      P_RESET: begin
        m.mem_rd = 1'b0; m.bus_err = 1'b0;
      end
      P_FETCH: begin
        e.mem_rd = 1'b1; e.pc_en = mr; e.ir_en = mr;
        m.iord = 1'b1; m.alu_srca = 1'b1; m.pc_src = 2'b11;
        e.alu_srcb = 2'd1; m.alu_srcb = 2'b11;
        e.alufn = 5'b00001; m.alufn = 5'h1F;
      end
      P_DECODE: begin
        e.alufn = 5'b00001; m.alufn = 5'h1F;
        m.alu_srca = 1'b1;
        e.alu_srcb = 2'd2; m.alu_srcb = 2'b11;
      end
      P_EXEC_R: begin
        e.alufn = ref_alufn(o, f); m.alufn = 5'h1F;
        e.alu_srca = 1'b1; m.alu_srca = 1'b1;
        m.alu_srcb = 2'b11;
      end
      P_EXEC_I: begin
        e.alufn = ref_alufn(o, f); m.alufn = 5'h1F;
        e.alu_srca = 1'b1; m.alu_srca = 1'b1;
        e.alu_srcb = (o == 6'h0C || o == 6'h0D || o == 6'h0E) ? 2'd3 : 2'd2;
        m.alu_srcb = 2'b11;
      end
      P_WB_ALU: begin
        e.reg_wr = 1'b1;
        e.reg_dst = (o == 6'h00) ? 2'd1 : 2'd0; m.reg_dst = 2'b11;
        e.wd_src = (o == 6'h0F) ? 2'd3 : 2'd0;  m.wd_src = 2'b11;
      end
      P_MEM_ADDR: begin
        e.alufn = 5'b00001; m.alufn = 5'h1F;
        e.alu_srca = 1'b1; m.alu_srca = 1'b1;
        e.alu_srcb = 2'd2; m.alu_srcb = 2'b11;
      end
      P_MEM_RD: begin
        e.iord = 1'b1; m.iord = 1'b1; e.mem_rd = 1'b1;
      end
      P_MEM_WR: begin
        e.iord = 1'b1; m.iord = 1'b1; e.mem_wr = 1'b1;
      end
      P_WB_MEM: begin
        e.reg_wr = 1'b1;
        e.wd_src = 2'd1; m.wd_src = 2'b11;
        e.reg_dst = 2'd0; m.reg_dst = 2'b11;
      end
      P_BRANCH: begin
        e.alufn = 5'b10001; m.alufn = 5'h1F;
        e.alu_srca = 1'b1; m.alu_srca = 1'b1;
        m.alu_srcb = 2'b11;
        e.pc_src = 2'd1; m.pc_src = 2'b11;
        e.pc_en = (o == 6'h04) ? z : ~z;
      end
      P_JUMP: begin
        e.pc_en = 1'b1;
        e.pc_src = (o == 6'h00) ? 2'd3 : 2'd2; m.pc_src = 2'b11;
        if (o == 6'h03) begin
          e.reg_wr = 1'b1;
          e.reg_dst = 2'd2; m.reg_dst = 2'b11;
          e.wd_src = 2'd2;  m.wd_src = 2'b11;
        end
      end
      default: ;
    endcase
  endtask

  // Drive one cycle of stimulus and queue its expected response
  task automatic cyc(input string tag, input ph_e ph, input logic [5:0] o,
                     input logic [5:0] f, input logic z, input logic mr,
                     input logic berr, input logic ill = 1'b0,
                     input logic ill_c = 1'b0);
    sb_t s;
    reset     = (ph == P_RESET) ? 1'b0 : 1'b1;
    op        = o;
    funct     = f;
    FlagZ     = z;
    mem_ready = mr;
    model(ph, o, f, z, mr, berr, s.e, s.m);
    s.tag   = tag;
    s.ill   = ill;
    s.ill_c = ill_c;
    sb_q.push_back(s);
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input string nm, input logic [5:0] o, input logic [5:0] f,
                         input logic z, input int n, input ph_e p0, input ph_e p1,
                         input ph_e p2, input ph_e p3, input ph_e p4);
    vec_t v;
    v.name = nm; v.op = o; v.funct = f; v.z = z; v.n = n;
    v.seq[0] = p0; v.seq[1] = p1; v.seq[2] = p2; v.seq[3] = p3; v.seq[4] = p4;
    vt.push_back(v);
  endtask

  // Compare DUT outputs against the oldest queued expectation
  always @(negedge clk) begin
    sb_t   s;
    outs_t a;
    if (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      a.alufn = ALUfn; a.alu_srca = alu_srca; a.alu_srcb = alu_srcb;
      a.pc_en = pc_en; a.pc_src = pc_src; a.ir_en = ir_en; a.iord = iord;
      a.mem_rd = mem_rd; a.mem_wr = mem_wr; a.reg_wr = reg_wr;
      a.reg_dst = reg_dst; a.wd_src = wd_src; a.bus_err = bus_err;
      checks++;
      if (((a ^ s.e) & s.m) != '0) begin
        failures++;
        $display("FAIL %s: outputs got=%06h want=%06h mask=%06h", s.tag, a, s.e, s.m);
      end
`ifdef MC_ILLEGAL_TRAP_EN
      if (s.ill_c) begin
        checks++;
        if (illegal_op !== s.ill) begin
          failures++;
          $display("FAIL %s: illegal_op got=%b want=%b", s.tag, illegal_op, s.ill);
        end
      end
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; op = '0; funct = '0; FlagZ = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #1;

    add_vec("add",    6'h00, 6'h20, 1'b0, 4, P_FETCH, P_DECODE, P_EXEC_R, P_WB_ALU, P_NONE);
    add_vec("sub",    6'h00, 6'h22, 1'b0, 4, P_FETCH, P_DECODE, P_EXEC_R, P_WB_ALU, P_NONE);
    add_vec("slt",    6'h00, 6'h2A, 1'b0, 4, P_FETCH, P_DECODE, P_EXEC_R, P_WB_ALU, P_NONE);
    add_vec("sra",    6'h00, 6'h03, 1'b0, 4, P_FETCH, P_DECODE, P_EXEC_R, P_WB_ALU, P_NONE);
    add_vec("nor",    6'h00, 6'h27, 1'b0, 4, P_FETCH, P_DECODE, P_EXEC_R, P_WB_ALU, P_NONE);
    add_vec("addi",   6'h08, 6'h00, 1'b0, 4, P_FETCH, P_DECODE, P_EXEC_I, P_WB_ALU, P_NONE);
    add_vec("sltiu",  6'h0B, 6'h00, 1'b0, 4, P_FETCH, P_DECODE, P_EXEC_I, P_WB_ALU, P_NONE);
    add_vec("ori",    6'h0D, 6'h00, 1'b0, 4, P_FETCH, P_DECODE, P_EXEC_I, P_WB_ALU, P_NONE);
    add_vec("lui",    6'h0F, 6'h00, 1'b0, 3, P_FETCH, P_DECODE, P_WB_ALU, P_NONE, P_NONE);
    add_vec("lw",     6'h23, 6'h00, 1'b0, 5, P_FETCH, P_DECODE, P_MEM_ADDR, P_MEM_RD, P_WB_MEM);
    add_vec("sw",     6'h2B, 6'h00, 1'b0, 4, P_FETCH, P_DECODE, P_MEM_ADDR, P_MEM_WR, P_NONE);
    add_vec("beq_z1", 6'h04, 6'h00, 1'b1, 3, P_FETCH, P_DECODE, P_BRANCH, P_NONE, P_NONE);
    add_vec("beq_z0", 6'h04, 6'h00, 1'b0, 3, P_FETCH, P_DECODE, P_BRANCH, P_NONE, P_NONE);
    add_vec("bne_z1", 6'h05, 6'h00, 1'b1, 3, P_FETCH, P_DECODE, P_BRANCH, P_NONE, P_NONE);
    add_vec("bne_z0", 6'h05, 6'h00, 1'b0, 3, P_FETCH, P_DECODE, P_BRANCH, P_NONE, P_NONE);
    add_vec("j",      6'h02, 6'h00, 1'b0, 3, P_FETCH, P_DECODE, P_JUMP, P_NONE, P_NONE);
    add_vec("jal",    6'h03, 6'h00, 1'b0, 3, P_FETCH, P_DECODE, P_JUMP, P_NONE, P_NONE);
    add_vec("jr",     6'h00, 6'h08, 1'b0, 3, P_FETCH, P_DECODE, P_JUMP, P_NONE, P_NONE);
`ifndef MC_ILLEGAL_TRAP_EN
    add_vec("ill_op", 6'h3F, 6'h00, 1'b0, 2, P_FETCH, P_DECODE, P_NONE, P_NONE, P_NONE);
    add_vec("ill_fn", 6'h00, 6'h3F, 1'b0, 2, P_FETCH, P_DECODE, P_NONE, P_NONE, P_NONE);
`endif
    add_vec("and",    6'h00, 6'h24, 1'b0, 4, P_FETCH, P_DECODE, P_EXEC_R, P_WB_ALU, P_NONE);

    // Reset held with memory ready: no strobes
    repeat (3) cyc("reset", P_RESET, 6'h00, 6'h20, 1'b0, 1'b1, 1'b0);

    // Single-instruction vectors, memory always ready
    foreach (vt[i]) begin
      for (int k = 0; k < vt[i].n; k++) begin
        cyc($sformatf("%s.%0d", vt[i].name, k), vt[i].seq[k], vt[i].op,
            vt[i].funct, vt[i].z, 1'b1, 1'b0);
      end
    end

    // lw with three idle cycles in MEM_RD
    cyc("lwwait.f", P_FETCH, 6'h23, 6'h00, 1'b0, 1'b1, 1'b0);
    cyc("lwwait.d", P_DECODE, 6'h23, 6'h00, 1'b0, 1'b1, 1'b0);
    cyc("lwwait.a", P_MEM_ADDR, 6'h23, 6'h00, 1'b0, 1'b1, 1'b0);
    repeat (3) cyc("lwwait.rd0", P_MEM_RD, 6'h23, 6'h00, 1'b0, 1'b0, 1'b0);
    cyc("lwwait.rd1", P_MEM_RD, 6'h23, 6'h00, 1'b0, 1'b1, 1'b0);
    cyc("lwwait.wb", P_WB_MEM, 6'h23, 6'h00, 1'b0, 1'b1, 1'b0);

    // sw whose ready arrives exactly on the limit cycle: completes normally
    cyc("swlim.f", P_FETCH, 6'h2B, 6'h00, 1'b0, 1'b1, 1'b0);
    cyc("swlim.d", P_DECODE, 6'h2B, 6'h00, 1'b0, 1'b1, 1'b0);
    cyc("swlim.a", P_MEM_ADDR, 6'h2B, 6'h00, 1'b0, 1'b1, 1'b0);
    repeat (15) cyc("swlim.wr0", P_MEM_WR, 6'h2B, 6'h00, 1'b0, 1'b0, 1'b0);
    cyc("swlim.wr1", P_MEM_WR, 6'h2B, 6'h00, 1'b0, 1'b1, 1'b0);
    cyc("swlim.next", P_FETCH, 6'h00, 6'h20, 1'b0, 1'b1, 1'b0);
    cyc("swlim.nd", P_DECODE, 6'h00, 6'h20, 1'b0, 1'b1, 1'b0);
    cyc("swlim.ne", P_EXEC_R, 6'h00, 6'h20, 1'b0, 1'b1, 1'b0);
    cyc("swlim.nw", P_WB_ALU, 6'h00, 6'h20, 1'b0, 1'b1, 1'b0);

    // Memory never ready in FETCH: bus error, halt, then recovery by reset
    repeat (16) cyc("buserr.wait", P_FETCH, 6'h08, 6'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc("buserr.halt", P_HALT, 6'h08, 6'h00, 1'b0, 1'b1, 1'b1);
    cyc("buserr.rst", P_RESET, 6'h08, 6'h00, 1'b0, 1'b1, 1'b0);
    cyc("buserr.f", P_FETCH, 6'h08, 6'h00, 1'b0, 1'b1, 1'b0);
    cyc("buserr.d", P_DECODE, 6'h08, 6'h00, 1'b0, 1'b1, 1'b0);
    cyc("buserr.e", P_EXEC_I, 6'h08, 6'h00, 1'b0, 1'b1, 1'b0);
    cyc("buserr.w", P_WB_ALU, 6'h08, 6'h00, 1'b0, 1'b1, 1'b0);

`ifdef MC_ILLEGAL_TRAP_EN
    // Unknown opcode traps into HALT with a sticky flag
    cyc("trap.f", P_FETCH, 6'h3F, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("trap.d", P_DECODE, 6'h3F, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (2) cyc("trap.halt", P_HALT, 6'h3F, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc("trap.rst", P_RESET, 6'h00, 6'h20, 1'b0, 1'b1, 1'b0);
    cyc("trap.f2", P_FETCH, 6'h00, 6'h20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
`endif

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mc_control_fsm
`default_nettype wire
